// File: rtl/counter_sequencer_pkg.sv
// Shared types for the counter sequencer: FSM state encoding.
package counter_sequencer_pkg;

    // Sequencer phases: wait for a command, reload the counter, sweep, report completion
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

endpackage : counter_sequencer_pkg

// File: rtl/counter_sequencer_counter.sv
// Parameterized up/down counter with synchronous load and count enable.
// Load has priority over enable; direction 1 counts up, 0 counts down.
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             direction,
    output logic [WIDTH-1:0] count
);

    // Count register: load wins over enable, otherwise step in the requested direction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            if (direction) begin
                count <= count + WIDTH'(1);
            end else begin
                count <= count - WIDTH'(1);
            end
        end
    end

endmodule : counter

// File: rtl/counter_sequencer.sv
// Command-driven sweep sequencer. Accepts start/target/repeat/ping-pong commands
// over valid/ready and steers one up/down counter through the requested passes.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic [REP_W-1:0] cmd_reps,
    input  logic             cmd_pingpong,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             pass_done,
    output logic             done
);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [WIDTH-1:0] cur_start;
    logic [WIDTH-1:0] cur_target;
    logic             dir;
    logic             pingpong;
    logic [REP_W-1:0] remaining;
    logic             at_target;
    logic             last_pass;
    logic             accept;
    logic             cnt_load;
    logic             cnt_enable;
    logic             counter_reset;

    assign at_target     = (count == cur_target);
    assign last_pass     = (remaining == REP_W'(1));
    assign accept        = cmd_valid && cmd_ready;
    assign counter_reset = ~rst_n;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: abort from any busy state returns to IDLE at once
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = abort ? IDLE : RUN;
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (at_target) begin
                    if (last_pass) begin
                        state_next = DONE;
                    end else if (pingpong) begin
                        state_next = RUN;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode: counter controls and status; events are masked in an abort cycle
    always_comb begin
        cmd_ready  = (state == IDLE);
        busy       = (state != IDLE);
        cnt_load   = (state == LOAD) && !abort;
        cnt_enable = (state == RUN) && !at_target;
        pass_done  = (state == RUN) && at_target && !abort;
        done       = (state == DONE) && !abort;
    end

    // Command registers: capture on handshake, swap endpoints on ping-pong turnaround
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_start  <= '0;
            cur_target <= '0;
            dir        <= 1'b1;
            pingpong   <= 1'b0;
            remaining  <= '0;
        end else if (accept) begin
            cur_start  <= cmd_start;
            cur_target <= cmd_target;
            dir        <= (cmd_target >= cmd_start);
            pingpong   <= cmd_pingpong;
            remaining  <= (cmd_reps == '0) ? REP_W'(1) : cmd_reps;
        end else if ((state == RUN) && at_target && !abort) begin
            remaining <= remaining - REP_W'(1);
            if (!last_pass && pingpong) begin
                cur_start  <= cur_target;
                cur_target <= cur_start;
                dir        <= ~dir;
            end
        end
    end

    counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk       (clk),
        .reset     (counter_reset),
        .load      (cnt_load),
        .load_value(cur_start),
        .enable    (cnt_enable),
        .direction (dir),
        .count     (count)
    );

endmodule : counter_sequencer

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer. A trace model expands each accepted
// command into the expected per-cycle outputs; a negedge process compares them.
module tb_counter_sequencer;

    localparam int WIDTH = 8;
    localparam int REP_W = 8;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_start;
    logic [WIDTH-1:0] cmd_target;
    logic [REP_W-1:0] cmd_reps;
    logic             cmd_pingpong;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             pass_done;
    logic             done;

    typedef struct {
        int count;
        bit pd;
        bit dn;
        int step;
    } exp_t;

    exp_t exp_q[$];
    int   pd_log[$];
    int   model_count = 0;
    int   neg_cyc = 0;
    int   accept_cyc = 0;
    int   done_rel = -1;
    int   n_compared = 0;
    int   n_mismatched = 0;

    counter_sequencer #(
        .WIDTH(WIDTH),
        .REP_W(REP_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_start   (cmd_start),
        .cmd_target  (cmd_target),
        .cmd_reps    (cmd_reps),
        .cmd_pingpong(cmd_pingpong),
        .abort       (abort),
        .count       (count),
        .busy        (busy),
        .pass_done   (pass_done),
        .done        (done)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkIdleOutputs();
        checkOutput("idle_count", int'(count), model_count);
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("idle_ready", int'(cmd_ready), 1);
        checkOutput("idle_pass_done", int'(pass_done), 0);
        checkOutput("idle_done", int'(done), 0);
    endtask

    // Expand one command into cycle-by-cycle expectations: a LOAD cycle, then each
    // pass walks from its start to its target with pass_done on arrival; reload
    // passes are preceded by another LOAD, ping-pong passes reverse the endpoints.
    task automatic buildTrace(input int s, input int t, input int reps, input bit pp);
        int   n;
        int   a;
        int   b;
        int   tmp;
        int   stepv;
        int   last;
        exp_t e;
        n = (reps == 0) ? 1 : reps;
        a = s;
        b = t;
        last = model_count;
        e = '{count: model_count, pd: 1'b0, dn: 1'b0, step: 0};
        exp_q.push_back(e);
        for (int p = 0; p < n; p++) begin
            if (p > 0 && !pp) begin
                e = '{count: b, pd: 1'b0, dn: 1'b0, step: 0};
                exp_q.push_back(e);
            end
            stepv = (b > a) ? 1 : -1;
            for (int v = a; v != b; v += stepv) begin
                e = '{count: v, pd: 1'b0, dn: 1'b0, step: stepv};
                exp_q.push_back(e);
            end
            e = '{count: b, pd: 1'b1, dn: 1'b0, step: 0};
            exp_q.push_back(e);
            last = b;
            if (pp) begin
                tmp = a;
                a = b;
                b = tmp;
            end
        end
        e = '{count: last, pd: 1'b0, dn: 1'b1, step: 0};
        exp_q.push_back(e);
    endtask

    // Compare process: check every cycle against the model, log event timing
    always @(negedge clk) begin : cmp_proc
        exp_t e;
        neg_cyc++;
        if (!rst_n) begin
            exp_q.delete();
            model_count = 0;
            checkIdleOutputs();
        end else if (exp_q.size() == 0) begin
            checkIdleOutputs();
            if (cmd_valid) begin
                accept_cyc = neg_cyc;
                pd_log.delete();
                done_rel = -1;
                buildTrace(int'(cmd_start), int'(cmd_target), int'(cmd_reps), cmd_pingpong);
            end
        end else begin
            e = exp_q.pop_front();
            if (abort) begin
                e.pd = 1'b0;
                e.dn = 1'b0;
            end
            checkOutput("run_count", int'(count), e.count);
            checkOutput("run_busy", int'(busy), 1);
            checkOutput("run_ready", int'(cmd_ready), 0);
            checkOutput("run_pass_done", int'(pass_done), int'(e.pd));
            checkOutput("run_done", int'(done), int'(e.dn));
            if (pass_done) pd_log.push_back(neg_cyc - accept_cyc);
            if (done) done_rel = neg_cyc - accept_cyc;
            if (abort) begin
                model_count = e.count + e.step;
                exp_q.delete();
            end else if (exp_q.size() == 0) begin
                model_count = e.count;
            end
        end
    end

    function automatic int pdAt(input int i);
        return (i < pd_log.size()) ? pd_log[i] : -1;
    endfunction

    // Offer one command; called 1 time unit after a rising edge
    task automatic applyStimulus(input int s, input int t, input int reps, input bit pp);
        int waited;
        waited = 0;
        while (busy && waited < 1000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (busy) checkOutput("wait_ready_timeout", 1, 0);
        cmd_start    = WIDTH'(s);
        cmd_target   = WIDTH'(t);
        cmd_reps     = REP_W'(reps);
        cmd_pingpong = pp;
        cmd_valid    = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || busy) && waited < 2000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (exp_q.size() != 0 || busy) checkOutput("wait_idle_timeout", 1, 0);
    endtask

    // Directed scenarios with hand-computed event timing
    initial begin
        int waited;
        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_start    = '0;
        cmd_target   = '0;
        cmd_reps     = '0;
        cmd_pingpong = 1'b0;
        abort        = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_count", int'(count), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single upward pass 3 -> 7
        applyStimulus(3, 7, 1, 0);
        waitIdle();
        checkOutput("t1_pd_count", pd_log.size(), 1);
        checkOutput("t1_pd_cycle", pdAt(0), 6);
        checkOutput("t1_done_cycle", done_rel, 7);
        checkOutput("t1_final_count", int'(count), 7);

        // Two reload passes downward 10 -> 4
        applyStimulus(10, 4, 2, 0);
        waitIdle();
        checkOutput("t2_pd_count", pd_log.size(), 2);
        checkOutput("t2_pd0_cycle", pdAt(0), 8);
        checkOutput("t2_pd1_cycle", pdAt(1), 16);
        checkOutput("t2_done_cycle", done_rel, 17);

        // Three ping-pong passes 0 <-> 2
        applyStimulus(0, 2, 3, 1);
        waitIdle();
        checkOutput("t3_pd_count", pd_log.size(), 3);
        checkOutput("t3_pd0_cycle", pdAt(0), 4);
        checkOutput("t3_pd1_cycle", pdAt(1), 7);
        checkOutput("t3_pd2_cycle", pdAt(2), 10);
        checkOutput("t3_done_cycle", done_rel, 11);
        checkOutput("t3_final_count", int'(count), 2);

        // start == target with reps = 0 is one immediate pass
        applyStimulus(5, 5, 0, 0);
        waitIdle();
        checkOutput("t4_pd_count", pd_log.size(), 1);
        checkOutput("t4_pd_cycle", pdAt(0), 2);
        checkOutput("t4_done_cycle", done_rel, 3);

        // Abort a long sweep when the count reaches 50
        applyStimulus(0, 255, 1, 0);
        waited = 0;
        while (count != 8'd50 && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("t5_reached_50", int'(count), 50);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("t5_busy_after_abort", int'(busy), 0);
        checkOutput("t5_count_after_abort", int'(count), 51);
        checkOutput("t5_no_done", done_rel, -1);
        checkOutput("t5_no_pd", pd_log.size(), 0);
        applyStimulus(51, 49, 1, 0);
        checkOutput("t5_new_cmd_busy", int'(busy), 1);
        waitIdle();
        checkOutput("t5_new_pd_cycle", pdAt(0), 4);
        checkOutput("t5_new_done_cycle", done_rel, 5);

        // Reset in the middle of a sweep, then a fresh ping-pong command
        applyStimulus(0, 100, 1, 0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("t6_reset_count", int'(count), 0);
        checkOutput("t6_reset_busy", int'(busy), 0);
        checkOutput("t6_reset_pd", int'(pass_done), 0);
        checkOutput("t6_reset_done", int'(done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("t6_ready_after", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        applyStimulus(2, 4, 2, 1);
        waitIdle();
        checkOutput("t6_pd_count", pd_log.size(), 2);
        checkOutput("t6_pd0_cycle", pdAt(0), 4);
        checkOutput("t6_pd1_cycle", pdAt(1), 7);
        checkOutput("t6_done_cycle", done_rel, 8);
        checkOutput("t6_final_count", int'(count), 2);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_counter_sequencer

// File: doc/counter_sequencer.md
# counter_sequencer

Command-driven sequencer that owns one instance of the team's parameterized up/down counter and drives its load, enable and direction controls. It accepts sweep commands over a valid/ready handshake (start value, target value, repeat count, ping-pong mode), then runs the counter through the requested passes. It reports per-pass and end-of-command events, and sits between the control/register layer and any logic that consumes the count.

## Interface
- WIDTH, default 8: count, start and target width.
- REP_W, default 8: repeat-count width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_start  in  WIDTH  first value of each pass.
- cmd_target  in  WIDTH  terminal value of each pass.
- cmd_reps  in  REP_W  number of passes; 0 is treated as 1.
- cmd_pingpong  in  1  1: alternate direction each pass; 0: reload start each pass.
- abort  in  1  cancel the active command.
- count  out  WIDTH  current counter value.
- busy  out  1  state != IDLE.
- pass_done  out  1  one-cycle pulse when a pass reaches its terminal value.
- done  out  1  one-cycle pulse when a command completes (not on abort).

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: cmd_ready=1. On handshake, capture start, target, reps (0→1) and pingpong. Set dir = (target >= start, unsigned), with 1 = up. Set cur_target = target, then go to LOAD.
- LOAD: drive counter load=1 with load_value=cur_start, then go to RUN.
- RUN, count != cur_target: drive enable=1 with direction=dir.
- RUN, count == cur_target: drive enable=0, pulse pass_done and decrement remaining. Then:
  - if remaining was 1, go to DONE;
  - else if pingpong, swap cur_start/cur_target, flip dir and stay in RUN;
  - else go to LOAD.
- DONE: pulse done, then go to IDLE.
- The counter never wraps, because the pass stops on equality and the direction always points toward the target.
- start == target: each pass completes in its first RUN cycle.
- abort, any non-IDLE state: go to IDLE next cycle. The counter holds its value. pass_done and done are suppressed in the abort cycle. abort in IDLE is ignored.
- A command offered while busy is stalled by cmd_ready=0; there is no queueing.
- Reset, including mid-command: state=IDLE, count=0, busy=0, pass_done=0, done=0, cmd_ready=1, remaining=0.

## Timing
- Accept the command in cycle 0.
- Cycle 1: LOAD.
- Cycle 2: count=start.
- count==target in cycle 2+|T−S|; pass_done is asserted in the same cycle.
- done is asserted in cycle 3+|T−S| for a single pass; cmd_ready returns in the next cycle.
- Reload mode: each extra pass costs |T−S|+2 cycles (match cycle plus LOAD).
- Ping-pong mode: each extra pass costs |T−S|+1 cycles.
- pass_done and done are combinational decodes of the registered state and count.
- cmd_ready and busy are decodes of the state only.

## Structure
- Package counter_sequencer_pkg holds the state enum typedef (IDLE, LOAD, RUN, DONE) and its encoding.
- The FSM, captured command registers and remaining counter live in counter_sequencer.
- Sub-module: the existing `counter` module, instantiated with WIDTH. Its active-high reset is driven from ~rst_n.

## Test plan
- WIDTH=8, start=3, target=7, reps=1, pingpong=0 → count 3,4,5,6,7; pass_done in cycle 6, done in cycle 7, cmd_ready=1 in cycle 8.
- start=10, target=4, reps=2, pingpong=0 → count 10..4 down, LOAD to 10, 10..4 again. Two pass_done pulses 8 cycles apart, then one done.
- start=0, target=2, reps=3, pingpong=1 → count 0,1,2,1,0,1,2 with no reload; pass_done at count 2, 0 and 2; done follows.
- start=5, target=5, reps=0 → treated as 1 pass; pass_done in cycle 2, done in cycle 3.
- abort at count=50 of a 0→255 sweep → next cycle busy=0, count holds 50 or 51 (the enable issued in the abort cycle still takes effect), done never pulses. A new command is accepted immediately.
- rst_n low mid-RUN → immediately count=0, busy=0, pass_done=0, done=0. After release, cmd_ready=1 and a new command runs normally.
